ahb_apb_bridge_param: RTL and testbench
=======================================

// Module: ahb_apb_bridge_param
// PURPOSE
//  Parametrised AHB-to-APB bridge: AHB slave on Hclk, drives NUM_SLV APB slaves in equal-size address regions.
//  Adds APB wait states (Pready), slave errors (Pslverr), two-cycle AHB ERROR response and a Pready timeout.
//  Sits between the AHB fabric/master and the APB peripheral cluster.
// PARAMETERS
//  ADDR_W       32            address width
//  DATA_W       32            data width
//  NUM_SLV      3             APB slave count; Pselx one-hot, bit i = slave i
//  BASE_ADDR    32'h8000_0000 base of slave 0 region
//  REGION_BITS  26            region size 2**REGION_BITS bytes; slave i base = BASE_ADDR + i<<REGION_BITS
//  TIMEOUT      16            max ACCESS cycles awaiting Pready; 0 disables timeout
// PORTS
//  Hclk       in   1        clock, all logic on rising edge
//  Hreset     in   1        synchronous reset, active-high
//  Hreadyin   in   1        AHB HREADY from fabric
//  Htrans     in   2        AHB transfer type (10 NONSEQ, 11 SEQ accepted)
//  Hwrite     in   1        AHB write
//  Haddr      in   ADDR_W   AHB address
//  Hwdata     in   DATA_W   AHB write data (data phase)
//  Hreadyout  out  1        AHB ready to fabric
//  Hresp      out  2        00 OKAY, 01 ERROR
//  Hrdata     out  DATA_W   AHB read data
//  Pselx      out  NUM_SLV  APB select, one-hot
//  Penable    out  1        APB enable
//  Pwrite     out  1        APB write
//  Paddr      out  ADDR_W   APB address
//  Pwdata     out  DATA_W   APB write data
//  Prdata     in   DATA_W   APB read data (shared, from selected slave)
//  Pready     in   1        APB ready
//  Pslverr    in   1        APB slave error
// BEHAVIOUR
//  Reset (Hreset=1 at edge): state IDLE, Pselx=0, Penable=0, Pwrite=0, Paddr=0, Pwdata=0, timeout cnt=0;
//   Hreadyout=1, Hresp=00, Hrdata=0. Reset mid-transfer aborts it; Pselx/Penable low after that edge, no response.
//  Accept: Hreadyin & Htrans[1] & Hreadyout -> capture Haddr, Hwrite, decoded select. Htrans IDLE/BUSY ignored.
//  Decode: idx=(Haddr-BASE_ADDR)>>REGION_BITS; mapped iff Haddr>=BASE_ADDR and idx<NUM_SLV, else unmapped.
//  States: IDLE, LATCH, SETUP, ACCESS, ERR1, ERR2.
//   IDLE:   Hreadyout=1. accept: unmapped->ERR1; mapped write->LATCH; mapped read->SETUP.
//   LATCH:  Hreadyout=0; Pwdata<=Hwdata at edge; ->SETUP.
//   SETUP:  Pselx=sel, Penable=0, Paddr/Pwrite from capture; Hreadyout=0; ->ACCESS.
//   ACCESS: Pselx=sel, Penable=1; cnt increments each cycle Pready=0.
//     Pready&~Pslverr: Hreadyout=1, Hresp=00, Hrdata=Prdata (reads); new accept -> per IDLE rules, else IDLE.
//     Pready&Pslverr: Hreadyout=0, Hresp=01 (first error cycle) -> ERR2.
//     ~Pready & cnt==TIMEOUT-1 (TIMEOUT>0): abort -> ERR1; no response this cycle.
//   ERR1:   Pselx=0, Penable=0, Hreadyout=0, Hresp=01; no accept -> ERR2.
//   ERR2:   Hreadyout=1, Hresp=01; accept allowed -> per IDLE rules, else IDLE.
//  Pselx/Penable/Paddr/Pwrite/Pwdata driven only from registers; no AHB-input combinational path to APB.
//  Paddr, Pwrite, Pwdata hold last values when Pselx=0; Pwdata unchanged by reads.
//  cnt cleared on entry to SETUP; width $clog2(TIMEOUT+1).
//  Latency (Pready=1, accept at cycle T): write done T+3, read done T+2, unmapped ERROR at T+1..T+2.
//  Back-to-back: accept in completing ACCESS/ERR2 cycle, no IDLE bubble.
//  Hrdata=0 when not completing a read; Hresp=00 except ERROR cycles.
// TESTING
//  1 Write 8000_0010 data DEAD_BEEF, Pready=1 -> Pselx=001 T+2, Penable T+3, Pwdata=DEAD_BEEF, Hreadyout=1 T+3, Hresp=00.
//  2 Read 8400_0004, Pready low 2 cycles, Prdata=1234_5678 -> Pselx=010, ACCESS 3 cycles, Hrdata=1234_5678 at Hreadyout=1.
//  3 Write 9000_0000 (unmapped) -> Pselx stays 000; Hresp=01 two cycles, Hreadyout 0 then 1.
//  4 Read 8800_0000, Pready=1 Pslverr=1 -> Pselx=100; Hresp=01 cycles T+2,T+3; Hreadyout 0 then 1.
//  5 Pready stuck 0, TIMEOUT=16 -> 16 ACCESS cycles, then Pselx=0, Hresp=01 two-cycle, then IDLE.
//  6 Write then read back-to-back 8000_0000 -> no idle gap; Hreset=1 mid-ACCESS -> next edge Pselx=0, Hreadyout=1.

Source files
------------

// File: rtl/ahb_apb_bridge_param.sv
// AHB-to-APB bridge with NUM_SLV equal-size APB regions, APB wait states,
// slave-error forwarding as a two-cycle AHB ERROR, and a Pready timeout.
module ahb_apb_bridge_param #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                NUM_SLV     = 3,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
    parameter int                REGION_BITS = 26,
    parameter int                TIMEOUT     = 16
) (
    input  logic               Hclk,
    input  logic               Hreset,
    input  logic               Hreadyin,
    input  logic [1:0]         Htrans,
    input  logic               Hwrite,
    input  logic [ADDR_W-1:0]  Haddr,
    input  logic [DATA_W-1:0]  Hwdata,
    output logic               Hreadyout,
    output logic [1:0]         Hresp,
    output logic [DATA_W-1:0]  Hrdata,
    output logic [NUM_SLV-1:0] Pselx,
    output logic               Penable,
    output logic               Pwrite,
    output logic [ADDR_W-1:0]  Paddr,
    output logic [DATA_W-1:0]  Pwdata,
    input  logic [DATA_W-1:0]  Prdata,
    input  logic               Pready,
    input  logic               Pslverr
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        SETUP,
        ACCESS,
        ERR1,
        ERR2
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    state_t              w_route;

    logic [ADDR_W-1:0]   r_addr;
    logic                r_write;
    logic [NUM_SLV-1:0]  r_sel;
    logic [NUM_SLV-1:0]  r_psel;
    logic                r_penable;
    logic                r_pwrite;
    logic [ADDR_W-1:0]   r_paddr;
    logic [DATA_W-1:0]   r_pwdata;
    logic [CNT_W-1:0]    r_cnt;

    logic [ADDR_W-1:0]   w_offset;
    logic [ADDR_W-1:0]   w_idx;
    logic                w_mapped;
    logic [NUM_SLV-1:0]  w_decSel;
    logic                w_accept;
    logic                w_timeout;
    logic                w_fromLatch;
    logic                w_unused;

    assign w_unused = Htrans[0];

    // Region index is the offset above the base; anything below the base or
    // past the last slave region is unmapped and answered with ERROR.
    assign w_offset = Haddr - BASE_ADDR;
    assign w_idx    = w_offset >> REGION_BITS;
    assign w_mapped = (Haddr >= BASE_ADDR) && (w_idx < ADDR_W'(NUM_SLV));

    always_comb begin
        w_decSel = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (w_mapped && (w_idx == ADDR_W'(i))) begin
                w_decSel[i] = 1'b1;
            end
        end
    end

    generate
        if (TIMEOUT > 0) begin : g_timeout
            assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));
        end else begin : g_noTimeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    always_comb begin
        Hreadyout = 1'b0;
        Hresp     = 2'b00;
        Hrdata    = '0;
        case (r_state)
            IDLE: begin
                Hreadyout = 1'b1;
            end
            ACCESS: begin
                if (Pready && !Pslverr) begin
                    Hreadyout = 1'b1;
                    if (!r_write) begin
                        Hrdata = Prdata;
                    end
                end else if (Pready) begin
                    Hresp = 2'b01;
                end
            end
            ERR1: begin
                Hresp = 2'b01;
            end
            ERR2: begin
                Hreadyout = 1'b1;
                Hresp     = 2'b01;
            end
            default: begin
            end
        endcase
    end

    assign w_accept    = Hreadyin && Htrans[1] && Hreadyout;
    assign w_route     = !w_mapped ? ERR1 : (Hwrite ? LATCH : SETUP);
    assign w_fromLatch = (r_state == LATCH);

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE, ERR2: begin
                w_nextState = w_accept ? w_route : IDLE;
            end
            LATCH: begin
                w_nextState = SETUP;
            end
            SETUP: begin
                w_nextState = ACCESS;
            end
            ACCESS: begin
                if (Pready && !Pslverr) begin
                    w_nextState = w_accept ? w_route : IDLE;
                end else if (Pready) begin
                    w_nextState = ERR2;
                end else if (w_timeout) begin
                    w_nextState = ERR1;
                end
            end
            ERR1: begin
                w_nextState = ERR2;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // APB signals are set up one edge ahead of the state they belong to, so the
    // bus is always driven from flops; reads skip LATCH and load Paddr from Haddr.
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            r_addr    <= '0;
            r_write   <= 1'b0;
            r_sel     <= '0;
            r_psel    <= '0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_cnt     <= '0;
        end else begin
            if (w_accept) begin
                r_addr  <= Haddr;
                r_write <= Hwrite;
                r_sel   <= w_decSel;
            end
            if (w_nextState == SETUP) begin
                r_psel   <= w_fromLatch ? r_sel : w_decSel;
                r_paddr  <= w_fromLatch ? r_addr : Haddr;
                r_pwrite <= w_fromLatch ? r_write : Hwrite;
            end else if (w_nextState != ACCESS) begin
                r_psel <= '0;
            end
            r_penable <= (w_nextState == ACCESS);
            if (r_state == LATCH) begin
                r_pwdata <= Hwdata;
            end
            if (w_nextState == SETUP) begin
                r_cnt <= '0;
            end else if ((r_state == ACCESS) && !Pready) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign Pselx   = r_psel;
    assign Penable = r_penable;
    assign Pwrite  = r_pwrite;
    assign Paddr   = r_paddr;
    assign Pwdata  = r_pwdata;

endmodule

// File: tb/tb_ahb_apb_bridge_param.sv
// Cycle-by-cycle vector bench for ahb_apb_bridge_param; each row holds the
// inputs for one clock cycle and the outputs expected in that same cycle.
module tb_ahb_apb_bridge_param;

    localparam logic [1:0]  NS = 2'b10;
    localparam logic [1:0]  ID = 2'b00;
    localparam logic [1:0]  BZ = 2'b01;
    localparam logic [31:0] PJ = 32'hA5A5_A5A5;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic [1:0]  trans;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] prdata;
        logic        pready;
        logic        pslverr;
        logic        eRdy;
        logic [1:0]  eResp;
        logic [31:0] eRdata;
        logic [2:0]  eSel;
        logic        eEn;
        logic        chkP;
        logic [31:0] ePaddr;
        logic        ePwrite;
        logic [31:0] ePwdata;
    } vec_t;

    logic        Hclk;
    logic        Hreset;
    logic        Hreadyin;
    logic [1:0]  Htrans;
    logic        Hwrite;
    logic [31:0] Haddr;
    logic [31:0] Hwdata;
    logic        Hreadyout;
    logic [1:0]  Hresp;
    logic [31:0] Hrdata;
    logic [2:0]  Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] Prdata;
    logic        Pready;
    logic        Pslverr;

    vec_t tbl[$];
    vec_t sbQ[$];
    int   checks;
    int   failures;
    int   rowIdx;

    ahb_apb_bridge_param dut (
        .Hclk      (Hclk),
        .Hreset    (Hreset),
        .Hreadyin  (Hreadyin),
        .Htrans    (Htrans),
        .Hwrite    (Hwrite),
        .Haddr     (Haddr),
        .Hwdata    (Hwdata),
        .Hreadyout (Hreadyout),
        .Hresp     (Hresp),
        .Hrdata    (Hrdata),
        .Pselx     (Pselx),
        .Penable   (Penable),
        .Pwrite    (Pwrite),
        .Paddr     (Paddr),
        .Pwdata    (Pwdata),
        .Prdata    (Prdata),
        .Pready    (Pready),
        .Pslverr   (Pslverr)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    function automatic vec_t mk(input logic rst, input logic rdy, input logic [1:0] trans,
                                input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] prdata, input logic pready, input logic pslverr,
                                input logic eRdy, input logic [1:0] eResp, input logic [31:0] eRdata,
                                input logic [2:0] eSel, input logic eEn);
        vec_t v;
        v.rst = rst;       v.rdy = rdy;       v.trans = trans;     v.wr = wr;
        v.addr = addr;     v.wdata = wdata;   v.prdata = prdata;
        v.pready = pready; v.pslverr = pslverr;
        v.eRdy = eRdy;     v.eResp = eResp;   v.eRdata = eRdata;
        v.eSel = eSel;     v.eEn = eEn;
        v.chkP = 1'b0;     v.ePaddr = '0;     v.ePwrite = 1'b0;    v.ePwdata = '0;
        return v;
    endfunction

    function automatic vec_t withP(input vec_t v, input logic [31:0] a, input logic w,
                                   input logic [31:0] d);
        vec_t r;
        r = v;
        r.chkP = 1'b1;
        r.ePaddr = a;
        r.ePwrite = w;
        r.ePwdata = d;
        return r;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL row %0d %s actual=%h required=%h", rowIdx, name, act, req);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        Hreset   = v.rst;
        Hreadyin = v.rdy;
        Htrans   = v.trans;
        Hwrite   = v.wr;
        Haddr    = v.addr;
        Hwdata   = v.wdata;
        Prdata   = v.prdata;
        Pready   = v.pready;
        Pslverr  = v.pslverr;
        sbQ.push_back(v);
    endtask

    task automatic checkOutput();
        vec_t e;
        if (sbQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL row %0d scoreboard actual=empty required=entry", rowIdx);
            return;
        end
        e = sbQ.pop_front();
        cmp("Hreadyout", 32'(Hreadyout), 32'(e.eRdy));
        cmp("Hresp",     32'(Hresp),     32'(e.eResp));
        cmp("Hrdata",    Hrdata,         e.eRdata);
        cmp("Pselx",     32'(Pselx),     32'(e.eSel));
        cmp("Penable",   32'(Penable),   32'(e.eEn));
        if (e.chkP) begin
            cmp("Paddr",  Paddr,         e.ePaddr);
            cmp("Pwrite", 32'(Pwrite),   32'(e.ePwrite));
            cmp("Pwdata", Pwdata,        e.ePwdata);
        end
    endtask

    task automatic buildTable();
        // write, read with two wait states, unmapped write
        tbl.push_back(withP(mk(0,1,NS,1,32'h8000_0010,0,PJ,1,0, 1,0,0,3'b000,0), 0, 0, 0));
        tbl.push_back(mk(0,1,ID,0,0,32'hDEAD_BEEF,PJ,1,0, 0,0,0,3'b000,0));
        tbl.push_back(withP(mk(0,1,ID,0,0,0,PJ,1,0, 0,0,0,3'b001,0), 32'h8000_0010, 1, 32'hDEAD_BEEF));
        tbl.push_back(withP(mk(0,1,ID,0,0,0,PJ,1,0, 1,0,0,3'b001,1), 32'h8000_0010, 1, 32'hDEAD_BEEF));
        tbl.push_back(mk(0,1,NS,0,32'h8400_0004,0,PJ,1,0, 1,0,0,3'b000,0));
        tbl.push_back(withP(mk(0,1,ID,0,0,0,PJ,0,0, 0,0,0,3'b010,0), 32'h8400_0004, 0, 32'hDEAD_BEEF));
        tbl.push_back(mk(0,1,ID,0,0,0,32'h1234_5678,0,0, 0,0,0,3'b010,1));
        tbl.push_back(mk(0,1,ID,0,0,0,32'h1234_5678,0,0, 0,0,0,3'b010,1));
        tbl.push_back(mk(0,1,ID,0,0,0,32'h1234_5678,1,0, 1,0,32'h1234_5678,3'b010,1));
        tbl.push_back(mk(0,1,NS,1,32'h9000_0000,0,PJ,1,0, 1,0,0,3'b000,0));
        tbl.push_back(withP(mk(0,1,ID,0,0,32'h1111_1111,PJ,1,0, 0,1,0,3'b000,0), 32'h8400_0004, 0, 32'hDEAD_BEEF));
        tbl.push_back(mk(0,1,ID,0,0,0,PJ,1,0, 1,1,0,3'b000,0));
        tbl.push_back(mk(0,1,ID,0,0,0,PJ,1,0, 1,0,0,3'b000,0));
        // slave error, then accepts in ERR2: below base, one past last region, last word
        tbl.push_back(mk(0,1,NS,0,32'h8800_0000,0,PJ,1,0, 1,0,0,3'b000,0));
        tbl.push_back(mk(0,1,ID,0,0,0,PJ,1,0, 0,0,0,3'b100,0));
        tbl.push_back(mk(0,1,ID,0,0,0,PJ,1,1, 0,1,0,3'b100,1));
        tbl.push_back(mk(0,1,NS,0,32'h7FFF_FFFC,0,PJ,1,0, 1,1,0,3'b000,0));
        tbl.push_back(mk(0,1,ID,0,0,0,PJ,1,0, 0,1,0,3'b000,0));
        tbl.push_back(mk(0,1,NS,0,32'h8C00_0000,0,PJ,1,0, 1,1,0,3'b000,0));
        tbl.push_back(mk(0,1,ID,0,0,0,PJ,1,0, 0,1,0,3'b000,0));
        tbl.push_back(mk(0,1,NS,0,32'h8BFF_FFFC,0,PJ,1,0, 1,1,0,3'b000,0));
        tbl.push_back(withP(mk(0,1,ID,0,0,0,PJ,1,0, 0,0,0,3'b100,0), 32'h8BFF_FFFC, 0, 32'hDEAD_BEEF));
        // back-to-back: read done + write accept, write done + read accept
        tbl.push_back(mk(0,1,NS,1,32'h8000_0000,0,32'hCAFE_0001,1,0, 1,0,32'hCAFE_0001,3'b100,1));
        tbl.push_back(mk(0,1,ID,0,0,32'h0BAD_F00D,PJ,1,0, 0,0,0,3'b000,0));
        tbl.push_back(withP(mk(0,1,ID,0,0,0,PJ,1,0, 0,0,0,3'b001,0), 32'h8000_0000, 1, 32'h0BAD_F00D));
        tbl.push_back(mk(0,1,NS,0,32'h8000_0000,0,PJ,1,0, 1,0,0,3'b001,1));
        tbl.push_back(withP(mk(0,1,ID,0,0,0,PJ,1,0, 0,0,0,3'b001,0), 32'h8000_0000, 0, 32'h0BAD_F00D));
        tbl.push_back(mk(0,1,ID,0,0,0,32'h0BAD_F00D,1,0, 1,0,32'h0BAD_F00D,3'b001,1));
        // BUSY and Hreadyin low must not start a transfer
        tbl.push_back(mk(0,1,BZ,0,32'h8000_0000,0,PJ,1,0, 1,0,0,3'b000,0));
        tbl.push_back(mk(0,0,NS,0,32'h8000_0000,0,PJ,1,0, 1,0,0,3'b000,0));
        tbl.push_back(mk(0,1,ID,0,0,0,PJ,1,0, 1,0,0,3'b000,0));
    endtask

    task automatic buildTimeout();
        tbl.push_back(mk(0,1,NS,0,32'h8400_0000,0,PJ,0,0, 1,0,0,3'b000,0));
        tbl.push_back(mk(0,1,ID,0,0,0,PJ,0,0, 0,0,0,3'b010,0));
        for (int k = 0; k < 16; k++) begin
            tbl.push_back(mk(0,1,ID,0,0,0,PJ,0,0, 0,0,0,3'b010,1));
        end
        tbl.push_back(mk(0,1,ID,0,0,0,PJ,0,0, 0,1,0,3'b000,0));
        tbl.push_back(mk(0,1,ID,0,0,0,PJ,0,0, 1,1,0,3'b000,0));
        tbl.push_back(mk(0,1,ID,0,0,0,PJ,1,0, 1,0,0,3'b000,0));
    endtask

    task automatic buildReset();
        tbl.push_back(mk(0,1,NS,1,32'h8800_0004,0,PJ,0,0, 1,0,0,3'b000,0));
        tbl.push_back(mk(0,1,ID,0,0,32'h5555_AAAA,PJ,0,0, 0,0,0,3'b000,0));
        tbl.push_back(withP(mk(0,1,ID,0,0,0,PJ,0,0, 0,0,0,3'b100,0), 32'h8800_0004, 1, 32'h5555_AAAA));
        tbl.push_back(mk(0,1,ID,0,0,0,PJ,0,0, 0,0,0,3'b100,1));
        tbl.push_back(mk(1,1,ID,0,0,0,PJ,0,0, 0,0,0,3'b100,1));
        tbl.push_back(withP(mk(0,1,ID,0,0,0,PJ,0,0, 1,0,0,3'b000,0), 0, 0, 0));
        tbl.push_back(mk(0,1,ID,0,0,0,PJ,1,0, 1,0,0,3'b000,0));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rowIdx   = 0;
        Hreset   = 1'b1;
        Hreadyin = 1'b1;
        Htrans   = ID;
        Hwrite   = 1'b0;
        Haddr    = '0;
        Hwdata   = '0;
        Prdata   = '0;
        Pready   = 1'b1;
        Pslverr  = 1'b0;
        buildTable();
        buildTimeout();
        buildReset();
        repeat (3) @(posedge Hclk);
        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge Hclk);
            #1;
            rowIdx = i;
            applyStimulus(tbl[i]);
            @(negedge Hclk);
            checkOutput();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
